// File: rtl/mac_dot_sequencer_if.sv
// rtl/mac_dot_sequencer_if.sv - job, operand, MAC-drive and result signals of the operand sequencer
`ifndef MAC_MIN_WIDTH
`define MAC_MIN_WIDTH 8
`endif
`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 32
`endif
`ifndef MAC_CONF_WIDTH
`define MAC_CONF_WIDTH 3
`endif

interface mac_dot_sequencer_if #(
  parameter int MIN_W  = `MAC_MIN_WIDTH,
  parameter int ACC_W  = `MAC_ACC_WIDTH,
  parameter int CONF_W = `MAC_CONF_WIDTH,
  parameter int LEN_W  = 9
);
  // job request
  logic                    start;
  logic [LEN_W-1:0]        len;
  logic [1:0]              mode;
  logic [ACC_W-1:0]        init_val;
  logic                    busy;
  logic                    err;
  // operand stream
  logic                    op_valid;
  logic                    op_ready;
  logic [4*MIN_W-1:0]      op_a;
  logic [MIN_W-1:0]        op_b;
  // MAC block drive
  logic                    mac_rst;
  logic                    mac_en;
  logic [MIN_W-1:0]        mac_a0;
  logic [MIN_W-1:0]        mac_a1;
  logic [MIN_W-1:0]        mac_a2;
  logic [MIN_W-1:0]        mac_a3;
  logic [MIN_W-1:0]        mac_b1;
  logic [ACC_W+CONF_W-1:0] mac_cfg;
  logic [ACC_W-1:0]        mac_c;
  // result
  logic                    res_valid;
  logic                    res_ready;
  logic [ACC_W-1:0]        res_data;

  modport master (
    output start, len, mode, init_val, op_valid, op_a, op_b, mac_c, res_ready,
    input  busy, err, op_ready, mac_rst, mac_en, mac_a0, mac_a1, mac_a2, mac_a3,
           mac_b1, mac_cfg, res_valid, res_data
  );

  modport slave (
    input  start, len, mode, init_val, op_valid, op_a, op_b, mac_c, res_ready,
    output busy, err, op_ready, mac_rst, mac_en, mac_a0, mac_a1, mac_a2, mac_a3,
           mac_b1, mac_cfg, res_valid, res_data
  );
endinterface

// File: rtl/mac_dot_sequencer.sv
// rtl/mac_dot_sequencer.sv - feeds operand beats into the MAC block and returns the dot product
`ifndef MAC_MIN_WIDTH
`define MAC_MIN_WIDTH 8
`endif
`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 32
`endif
`ifndef MAC_CONF_WIDTH
`define MAC_CONF_WIDTH 3
`endif

module mac_dot_sequencer #(
  parameter int MIN_W   = `MAC_MIN_WIDTH,
  parameter int ACC_W   = `MAC_ACC_WIDTH,
  parameter int CONF_W  = `MAC_CONF_WIDTH,
  parameter int MAX_LEN = 256
) (
  input  logic clk,
  input  logic rst,
  mac_dot_sequencer_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_DUAL   = 2'd1;
  localparam logic [1:0] MODE_BAD    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_RESULT
  } state_t;

  state_t                  state;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        beat_cnt;
  logic                    drain_cnt;

  logic                    busy_q;
  logic                    err_q;
  logic                    op_ready_q;
  logic                    mac_rst_q;
  logic                    mac_en_q;
  logic [MIN_W-1:0]        a0_q, a1_q, a2_q, a3_q, b1_q;
  logic [ACC_W+CONF_W-1:0] cfg_q;
  logic                    res_valid_q;
  logic [ACC_W-1:0]        res_data_q;

  logic                    job_ok;
  logic                    accept;
  logic                    last_beat;
  logic [MIN_W-1:0]        lane0, lane1, lane2, lane3;

  // job admission, beat handshake and lane slicing
  always_comb begin
    job_ok    = (bus.len != '0) && (bus.len <= LEN_W'(MAX_LEN)) && (bus.mode != MODE_BAD);
    accept    = op_ready_q && bus.op_valid;
    last_beat = (beat_cnt + LEN_W'(1)) == len_q;
    lane0     = bus.op_a[0*MIN_W +: MIN_W];
    lane1     = bus.op_a[1*MIN_W +: MIN_W];
    lane2     = bus.op_a[2*MIN_W +: MIN_W];
    lane3     = bus.op_a[3*MIN_W +: MIN_W];
  end

  // job FSM; every output is registered so the MAC sees clean, glitch-free drives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      len_q       <= '0;
      beat_cnt    <= '0;
      drain_cnt   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      op_ready_q  <= 1'b0;
      mac_rst_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      a0_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      a3_q        <= '0;
      b1_q        <= '0;
      cfg_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      err_q     <= 1'b0;
      mac_rst_q <= 1'b0;
      mac_en_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (job_ok) begin
              len_q     <= bus.len;
              beat_cnt  <= '0;
              cfg_q     <= {bus.init_val, 1'b1, bus.mode};
              busy_q    <= 1'b1;
              mac_rst_q <= 1'b1;
              state     <= S_CLEAR;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          op_ready_q <= 1'b1;
          state      <= S_STREAM;
        end
        S_STREAM: begin
          if (accept) begin
            mac_en_q <= 1'b1;
            b1_q     <= bus.op_b;
            a0_q     <= '0;
            a2_q     <= '0;
            a3_q     <= '0;
            case (cfg_q[1:0])
              MODE_SINGLE: a1_q <= lane0;
              MODE_DUAL: begin
                a0_q <= lane0;
                a1_q <= lane1;
              end
              default: begin
                a0_q <= lane0;
                a1_q <= lane1;
                a2_q <= lane2;
                a3_q <= lane3;
              end
            endcase
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (last_beat) begin
              op_ready_q <= 1'b0;
              drain_cnt  <= 1'b0;
              state      <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // first cycle carries the final mac_en, second lets the MAC output settle
          if (!drain_cnt) begin
            drain_cnt <= 1'b1;
          end else begin
            res_data_q  <= bus.mac_c;
            res_valid_q <= 1'b1;
            state       <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.op_ready  = op_ready_q;
  assign bus.mac_rst   = mac_rst_q;
  assign bus.mac_en    = mac_en_q;
  assign bus.mac_a0    = a0_q;
  assign bus.mac_a1    = a1_q;
  assign bus.mac_a2    = a2_q;
  assign bus.mac_a3    = a3_q;
  assign bus.mac_b1    = b1_q;
  assign bus.mac_cfg   = cfg_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb/tb_mac_dot_sequencer.sv - directed bench for mac_dot_sequencer with a behavioural MAC block
module tb_mac_dot_sequencer;

  localparam int MIN_W  = 8;
  localparam int ACC_W  = 32;
  localparam int CONF_W = 3;
  localparam int LEN_W  = 9;

  logic clk;
  logic rst;

  mac_dot_sequencer_if #(.MIN_W(MIN_W), .ACC_W(ACC_W), .CONF_W(CONF_W), .LEN_W(LEN_W)) bus ();

  mac_dot_sequencer #(.MIN_W(MIN_W), .ACC_W(ACC_W), .CONF_W(CONF_W), .MAX_LEN(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int en_count = 0;
  int en_base;

  logic [31:0] beat_a [0:255];
  logic [7:0]  beat_b [0:255];

  logic [31:0] mac_acc;
  logic [31:0] prod;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural MAC block: SINGLE uses A1, DUAL {A1,A0}, QUAD {A3..A0}, each times B1
  always_comb begin
    prod = '0;
    case (bus.mac_cfg[1:0])
      2'd0:    prod = {24'h0, bus.mac_a1} * {24'h0, bus.mac_b1};
      2'd1:    prod = {16'h0, bus.mac_a1, bus.mac_a0} * {24'h0, bus.mac_b1};
      default: prod = {bus.mac_a3, bus.mac_a2, bus.mac_a1, bus.mac_a0} * {24'h0, bus.mac_b1};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mac_acc <= '0;
    else if (bus.mac_rst) mac_acc <= bus.mac_cfg[34:3];
    else if (bus.mac_en) mac_acc <= mac_acc + prod;
  end

  assign bus.mac_c = mac_acc;

  always_ff @(posedge clk) begin
    if (bus.mac_en) en_count <= en_count + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [1:0] m, input logic [8:0] l, input logic [31:0] iv);
    bus.start    = 1'b1;
    bus.mode     = m;
    bus.len      = l;
    bus.init_val = iv;
    step();
    bus.start = 1'b0;
  endtask

  // sends n beats; with gaps, op_valid drops for one cycle between beats
  task automatic feed(input int n, input bit gaps);
    int guard;
    for (int i = 0; i < n; i++) begin
      bus.op_valid = 1'b1;
      bus.op_a     = beat_a[i];
      bus.op_b     = beat_b[i];
      guard = 0;
      while (!bus.op_ready && guard < 20) begin
        step();
        guard++;
      end
      check("op_ready_for_beat", bus.op_ready, 1);
      step();
      if (gaps && i != n - 1) begin
        bus.op_valid = 1'b0;
        step();
        check("gap_mac_en", bus.mac_en, 0);
      end
    end
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int guard;
    guard = 0;
    while (!bus.res_valid && guard < 20) begin
      step();
      guard++;
    end
    check("res_valid_wait", bus.res_valid, 1);
  endtask

  task automatic wait_result(input string tag, input logic [31:0] exp);
    wait_valid();
    check(tag, bus.res_data, exp);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("res_valid_drop", bus.res_valid, 0);
    check("busy_after_res", bus.busy, 0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.mode      = '0;
    bus.init_val  = '0;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b0;
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_op_ready", bus.op_ready, 0);
    check("rst_mac_rst", bus.mac_rst, 0);
    check("rst_mac_en", bus.mac_en, 0);
    check("rst_mac_cfg", bus.mac_cfg, 0);
    check("rst_mac_a1", bus.mac_a1, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    rst = 1'b0;
    step();

    // SINGLE, init 0, three beats -> 2*3 + 4*5 + 1*1 = 27
    start_job(2'd0, 9'd3, 32'd0);
    check("t1_clear_mac_rst", bus.mac_rst, 1);
    check("t1_clear_busy", bus.busy, 1);
    check("t1_clear_cfg", bus.mac_cfg, 35'h4);
    check("t1_clear_op_ready", bus.op_ready, 0);
    beat_a[0] = 32'hDDCCBB02; beat_b[0] = 8'd3;
    beat_a[1] = 32'hDDCCBB04; beat_b[1] = 8'd5;
    beat_a[2] = 32'hDDCCBB01; beat_b[2] = 8'd1;
    feed(3, 1'b0);
    check("t1_mac_en", bus.mac_en, 1);
    check("t1_mac_a1", bus.mac_a1, 8'h01);
    check("t1_mac_b1", bus.mac_b1, 8'h01);
    check("t1_mac_a0", bus.mac_a0, 0);
    check("t1_mac_a2", bus.mac_a2, 0);
    check("t1_mac_a3", bus.mac_a3, 0);
    check("t1_op_ready_drain", bus.op_ready, 0);
    wait_result("t1_res_data", 32'd27);

    // DUAL, init 100, one beat {0x01,0x03}*2 -> 618; then hold RESULT with start pulsed
    start_job(2'd1, 9'd1, 32'd100);
    check("t2_cfg", bus.mac_cfg, 35'd805);
    beat_a[0] = 32'hAABB0103; beat_b[0] = 8'd2;
    feed(1, 1'b0);
    check("t2_mac_a0", bus.mac_a0, 8'h03);
    check("t2_mac_a1", bus.mac_a1, 8'h01);
    check("t2_mac_a2", bus.mac_a2, 0);
    check("t2_mac_a3", bus.mac_a3, 0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("t4_res_valid", bus.res_valid, 1);
      check("t4_res_data", bus.res_data, 32'd618);
      check("t4_op_ready", bus.op_ready, 0);
      check("t4_busy", bus.busy, 1);
      check("t4_err", bus.err, 0);
      bus.start    = (i == 2);
      bus.len      = 9'd1;
      bus.mode     = 2'd0;
      bus.init_val = 32'd0;
      step();
    end
    check("t4_err_after", bus.err, 0);
    bus.start     = 1'b1;
    bus.res_ready = 1'b1;
    step();
    bus.start     = 1'b0;
    bus.res_ready = 1'b0;
    check("t4_res_valid_drop", bus.res_valid, 0);
    check("t4_busy_drop", bus.busy, 0);
    step();
    check("t4_no_new_job_busy", bus.busy, 0);
    check("t4_no_new_job_rst", bus.mac_rst, 0);

    // QUAD, four beats placing one lane each -> 0x04030201, gapless then gapped
    beat_a[0] = 32'h00000001; beat_b[0] = 8'd1;
    beat_a[1] = 32'h00000100; beat_b[1] = 8'd2;
    beat_a[2] = 32'h00010000; beat_b[2] = 8'd3;
    beat_a[3] = 32'h01000000; beat_b[3] = 8'd4;
    start_job(2'd2, 9'd4, 32'd0);
    en_base = en_count;
    feed(4, 1'b0);
    check("t3_mac_a3", bus.mac_a3, 8'h01);
    check("t3_mac_a0", bus.mac_a0, 0);
    wait_result("t3_res_gapless", 32'h04030201);
    check("t3_en_count_gapless", en_count - en_base, 4);
    start_job(2'd2, 9'd4, 32'd0);
    en_base = en_count;
    feed(4, 1'b1);
    wait_result("t3_res_gapped", 32'h04030201);
    check("t3_en_count_gapped", en_count - en_base, 4);

    // rejected starts: len 0, mode 3, len above 256
    bus.start = 1'b1; bus.len = 9'd0; bus.mode = 2'd0;
    step();
    check("t5_err_len0", bus.err, 1);
    check("t5_busy_len0", bus.busy, 0);
    bus.start = 1'b0;
    step();
    check("t5_err_clear", bus.err, 0);
    bus.start = 1'b1; bus.len = 9'd1; bus.mode = 2'd3;
    step();
    check("t5_err_mode3", bus.err, 1);
    check("t5_busy_mode3", bus.busy, 0);
    bus.start = 1'b0;
    step();
    check("t5_err_clear2", bus.err, 0);
    bus.start = 1'b1; bus.len = 9'd257; bus.mode = 2'd0;
    step();
    check("t5_err_len257", bus.err, 1);
    bus.start = 1'b0;
    step();
    check("t5_busy_end", bus.busy, 0);

    // maximum length job, init 5, 256 beats of 1*1 -> 261
    for (int i = 0; i < 256; i++) begin
      beat_a[i] = 32'h00000001;
      beat_b[i] = 8'd1;
    end
    start_job(2'd0, 9'd256, 32'd5);
    feed(256, 1'b0);
    wait_result("max_len_res", 32'd261);

    // reset in the middle of a 5-beat job, then a fresh one-beat job 3*3
    beat_a[0] = 32'h00000002; beat_b[0] = 8'd2;
    beat_a[1] = 32'h00000002; beat_b[1] = 8'd2;
    start_job(2'd0, 9'd5, 32'd0);
    feed(2, 1'b0);
    bus.op_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("t6_busy", bus.busy, 0);
    check("t6_op_ready", bus.op_ready, 0);
    check("t6_mac_en", bus.mac_en, 0);
    check("t6_mac_rst", bus.mac_rst, 0);
    check("t6_mac_cfg", bus.mac_cfg, 0);
    check("t6_mac_a1", bus.mac_a1, 0);
    check("t6_mac_b1", bus.mac_b1, 0);
    check("t6_res_valid", bus.res_valid, 0);
    step();
    check("t6_mac_rst_held", bus.mac_rst, 0);
    check("t6_res_data_held", bus.res_data, 0);
    rst = 1'b0;
    bus.op_valid = 1'b0;
    step();
    beat_a[0] = 32'h00000003; beat_b[0] = 8'd3;
    start_job(2'd0, 9'd1, 32'd0);
    feed(1, 1'b0);
    wait_result("t6_res_after_rst", 32'd9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
